// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the memory access bridge: size encodings, FSM states
// and little-endian lane helpers.
package mem_bridge_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StErr,
        StWr,
        StRdWait,
        StCapture,
        StRmwWr
    } bridge_state_e;

    // Illegal size or an offset not aligned to the access size.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_WORD: bad = (off != 2'b00);
            SZ_HALF: bad = off[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [15:0] lane_half(input logic [31:0] word, input logic j);
        logic [15:0] h;
        if (j) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        return h;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: extracts/extends a load lane from a memory word and
// merges sub-word store data into an old word.
module byte_lane_unit
    import mem_bridge_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_ext;
    logic        half_ext;

    always_comb begin
        byte_sel = lane_byte(word_i, off_i);
        half_sel = lane_half(word_i, off_i[1]);
        byte_ext = ~uns_i & byte_sel[7];
        half_ext = ~uns_i & half_sel[15];
        load_o   = word_i;
        case (size_i)
            SZ_BYTE: load_o = {{24{byte_ext}}, byte_sel};
            SZ_HALF: load_o = {{16{half_ext}}, half_sel};
            default: load_o = word_i;
        endcase
    end

    always_comb begin
        merge_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                case (off_i)
                    2'd0:    merge_o[7:0]   = wdata_i[7:0];
                    2'd1:    merge_o[15:8]  = wdata_i[7:0];
                    2'd2:    merge_o[23:16] = wdata_i[7:0];
                    default: merge_o[31:24] = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off_i[1]) begin
                    merge_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_o[15:0] = wdata_i[15:0];
                end
            end
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_bridge.sv
// Sequences one datapath load/store into word-wide synchronous memory cycles,
// using read-modify-write for sub-word stores and flagging misaligned accesses.
module mem_access_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    // RD_WAIT spans MEM_LAT+1 cycles: one to present the address, MEM_LAT to read.
    localparam logic [1:0] LatLast = 2'(MEM_LAT);

    bridge_state_e state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   din_q, din_d;

    logic [31:0]   load_word;
    logic [31:0]   merge_word;

    byte_lane_unit u_lane (
        .word_i  (mem_dout),
        .wdata_i (wdata_q),
        .off_i   (addr_q[1:0]),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .load_o  (load_word),
        .merge_o (merge_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        din_d   = din_q;

        case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    wr_d    = wr;
                    size_d  = size;
                    uns_d   = uns;
                    cnt_d   = 2'd0;
                    if (access_err(size, addr[1:0])) begin
                        state_d = StErr;
                    end else if (wr && (size == SZ_WORD)) begin
                        din_d   = wdata;
                        state_d = StWr;
                    end else begin
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                if (cnt_q == LatLast) begin
                    if (wr_q) begin
                        din_d   = merge_word;
                        state_d = StRmwWr;
                    end else begin
                        rdata_d = load_word;
                        state_d = StCapture;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StErr, StWr, StCapture, StRmwWr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        done   = 1'b0;
        err    = 1'b0;
        mem_wr = 1'b0;
        case (state_q)
            StErr: begin
                done = 1'b1;
                err  = 1'b1;
            end
            StWr, StRmwWr: begin
                done   = 1'b1;
                mem_wr = ~reset;
            end
            StCapture: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign rdata    = rdata_q;
    assign mem_din  = din_q;
    assign mem_addr = {addr_q[31:2], 2'b00};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rdata_q <= 32'd0;
            din_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            din_q   <= din_d;
        end
    end

endmodule

// File: tb/tb_mem_access_bridge.sv
// Directed scoreboard bench for mem_access_bridge with a one-cycle-latency
// synchronous memory model.
module tb_mem_access_bridge;

    localparam int unsigned MEM_LAT = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] mem [256];
    int          total = 0;
    int          bad = 0;
    int          wr_count = 0;
    int          err_wr = 0;
    logic [31:0] last_waddr = 32'd0;
    logic [31:0] last_wdin = 32'd0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    mem_access_bridge #(
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .wr       (wr),
        .size     (size),
        .uns      (uns),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always @(posedge clock) begin
        if (mem_wr) begin
            mem[mem_addr[9:2]] <= mem_din;
            wr_count           <= wr_count + 1;
            last_waddr         <= mem_addr;
            last_wdin          <= mem_din;
        end
        if (err && mem_wr) begin
            err_wr <= err_wr + 1;
        end
        mem_dout <= mem[mem_addr[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic access(input string tag, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] wd,
                          input logic hold, input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int exp_writes);
        exp_t e;
        exp_t got;
        int   k;
        int   w0;
        e.tag    = tag;
        e.rdata  = exp_rd;
        e.err    = exp_err;
        e.lat    = exp_lat;
        e.writes = exp_writes;
        sb.push_back(e);
        w0    = wr_count;
        req   = 1'b1;
        wr    = w;
        size  = sz;
        uns   = u;
        addr  = a;
        wdata = wd;
        k     = 0;
        do begin
            @(posedge clock);
            #1;
            k++;
            if (!hold) req = 1'b0;
        end while (!done && k < 20);
        req = 1'b0;
        got = sb.pop_front();
        check({got.tag, " done"}, {31'd0, done}, 32'd1);
        check({got.tag, " latency"}, k, got.lat);
        check({got.tag, " err"}, {31'd0, err}, {31'd0, got.err});
        check({got.tag, " rdata"}, rdata, got.rdata);
        @(posedge clock);
        #1;
        check({got.tag, " busy after"}, {31'd0, busy}, 32'd0);
        check({got.tag, " done pulse"}, {31'd0, done}, 32'd0);
        check({got.tag, " writes"}, wr_count - w0, got.writes);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h40] = 32'h8899AABB;
        reset = 1'b1;
        req   = 1'b0;
        wr    = 1'b0;
        size  = 2'b00;
        uns   = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("reset rdata", rdata, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset mem_wr", {31'd0, mem_wr}, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_din", mem_din, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        access("ld b 103 s", 1'b0, 2'b10, 1'b0, 32'h103, 32'd0, 1'b0, 32'hFFFFFF88, 1'b0, 3, 0);
        access("ld h 102 u", 1'b0, 2'b01, 1'b1, 32'h102, 32'd0, 1'b0, 32'h00008899, 1'b0, 3, 0);
        access("ld b 100 s", 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 1'b0, 32'hFFFFFFBB, 1'b0, 3, 0);

        access("st b 101", 1'b1, 2'b10, 1'b0, 32'h101, 32'h000000CC, 1'b1, 32'hFFFFFFBB, 1'b0,
               3, 1);
        check("st b waddr", last_waddr, 32'h100);
        check("st b wdin", last_wdin, 32'h8899CCBB);
        access("ld w 100", 1'b0, 2'b00, 1'b0, 32'h100, 32'd0, 1'b0, 32'h8899CCBB, 1'b0, 3, 0);

        access("st w 100", 1'b1, 2'b00, 1'b0, 32'h100, 32'h12345678, 1'b1, 32'h8899CCBB, 1'b0,
               1, 1);
        check("st w wdin", last_wdin, 32'h12345678);
        check("st w mem", mem[8'h40], 32'h12345678);

        access("err ld h 101", 1'b0, 2'b01, 1'b0, 32'h101, 32'd0, 1'b0, 32'h8899CCBB, 1'b1, 1, 0);
        access("err size 11", 1'b0, 2'b11, 1'b0, 32'h100, 32'd0, 1'b0, 32'h8899CCBB, 1'b1, 1, 0);
        access("err st w 102", 1'b1, 2'b00, 1'b0, 32'h102, 32'hDEADBEEF, 1'b0, 32'h8899CCBB,
               1'b1, 1, 0);
        access("ld h 102 s", 1'b0, 2'b01, 1'b0, 32'h102, 32'd0, 1'b0, 32'h00001234, 1'b0, 3, 0);

        // Byte store aborted by reset in its write cycle.
        w0    = wr_count;
        req   = 1'b1;
        wr    = 1'b1;
        size  = 2'b10;
        uns   = 1'b0;
        addr  = 32'h100;
        wdata = 32'h00000055;
        @(posedge clock);
        #1;
        req = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check("rst rmw busy", {31'd0, busy}, 32'd1);
        check("rst rmw din", mem_din, 32'h12345655);
        reset = 1'b1;
        #1;
        check("rst mem_wr gated", {31'd0, mem_wr}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst mem kept", mem[8'h40], 32'h12345678);
        check("rst no write", wr_count - w0, 32'd0);
        access("post rst ld w", 1'b0, 2'b00, 1'b0, 32'h100, 32'd0, 1'b0, 32'h12345678, 1'b0, 3, 0);

        check("err with mem_wr", err_wr, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
